// File: rtl/multi_func_alu_seq.sv
// Registered multi-function ALU with a valid/ready request/result interface.
// Single-cycle logic/arith/shift/compare ops; MUL is iterative shift-add, one bit of B per cycle.
module multi_func_alu_seq #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk_xi,
    input  logic             rst_n_xi,
    input  logic             in_valid_xi,
    output logic             in_ready_xo,
    input  logic [3:0]       op_xi,
    input  logic [WIDTH-1:0] a_xi,
    input  logic [WIDTH-1:0] b_xi,
    output logic             out_valid_xo,
    input  logic             out_ready_xi,
    output logic [WIDTH-1:0] f_xo,
    output logic             zero_xo,
    output logic             neg_xo,
    output logic             carry_xo,
    output logic             ovf_xo,
    output logic             illegal_xo
);
    // Handshakes: a request transfers on a rising edge where in_valid_xi & in_ready_xo;
    // a result transfers on a rising edge where out_valid_xo & out_ready_xi.
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [3:0] OP_MUL = 4'd11;

    state_t               state;
    state_t               state_next;
    logic                 accept;
    logic [WIDTH-1:0]     mcand;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_step;
    logic [WIDTH:0]       mul_sum;
    logic [SHW:0]         cnt;
    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       diff;
    logic [WIDTH-1:0]     res_f;
    logic                 res_c;
    logic                 res_v;
    logic                 res_il;
    logic [SHW-1:0]       sh;

    assign accept = in_valid_xi & in_ready_xo;

    always_ff @(posedge clk_xi or negedge rst_n_xi) begin
        if (!rst_n_xi) state <= IDLE;
        else           state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = (op_xi == OP_MUL) ? BUSY : DONE;
            BUSY: if (cnt[SHW]) state_next = DONE;
            DONE: begin
                if (out_ready_xi) begin
                    if (accept) state_next = (op_xi == OP_MUL) ? BUSY : DONE;
                    else        state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        out_valid_xo = (state == DONE);
        in_ready_xo  = (state == IDLE) | ((state == DONE) & out_ready_xi);
    end

    // Single-cycle result path, evaluated directly on the request inputs.
    always_comb begin
        res_f  = '0;
        res_c  = 1'b0;
        res_v  = 1'b0;
        res_il = 1'b0;
        sh     = a_xi[SHW-1:0];
        sum    = {1'b0, a_xi} + {1'b0, b_xi};
        diff   = {1'b0, a_xi} - {1'b0, b_xi};
        case (op_xi)
            4'd0: res_f = a_xi & b_xi;
            4'd1: res_f = a_xi | b_xi;
            4'd2: res_f = a_xi ^ b_xi;
            4'd3: res_f = ~(a_xi | b_xi);
            4'd4: begin
                res_f = sum[WIDTH-1:0];
                res_c = sum[WIDTH];
                res_v = (a_xi[WIDTH-1] == b_xi[WIDTH-1]) & (sum[WIDTH-1] != a_xi[WIDTH-1]);
            end
            4'd5: begin
                res_f = diff[WIDTH-1:0];
                res_c = diff[WIDTH];
                res_v = (a_xi[WIDTH-1] != b_xi[WIDTH-1]) & (diff[WIDTH-1] != a_xi[WIDTH-1]);
            end
            4'd6:  res_f = {{(WIDTH-1){1'b0}}, (a_xi < b_xi)};
            4'd7:  res_f = b_xi << sh;
            4'd8:  res_f = b_xi >> sh;
            4'd9:  res_f = $signed(b_xi) >>> sh;
            4'd10: res_f = {{(WIDTH-1){1'b0}}, ($signed(a_xi) < $signed(b_xi))};
            OP_MUL: res_f = '0;
            default: res_il = 1'b1;
        endcase
    end

    // Shift-add step: low half of acc starts as B and shifts out one multiplier bit per cycle.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        acc_step = {mul_sum, acc[WIDTH-1:1]};
    end

    // cnt runs 0..WIDTH: WIDTH step cycles, then one cycle that publishes the product.
    always_ff @(posedge clk_xi or negedge rst_n_xi) begin
        if (!rst_n_xi) begin
            mcand      <= '0;
            acc        <= '0;
            cnt        <= '0;
            f_xo       <= '0;
            zero_xo    <= 1'b0;
            neg_xo     <= 1'b0;
            carry_xo   <= 1'b0;
            ovf_xo     <= 1'b0;
            illegal_xo <= 1'b0;
        end else if (accept) begin
            if (op_xi == OP_MUL) begin
                mcand <= a_xi;
                acc   <= {{WIDTH{1'b0}}, b_xi};
                cnt   <= '0;
            end else begin
                f_xo       <= res_f;
                zero_xo    <= (res_f == '0) & ~res_il;
                neg_xo     <= res_f[WIDTH-1];
                carry_xo   <= res_c;
                ovf_xo     <= res_v;
                illegal_xo <= res_il;
            end
        end else if (state == BUSY) begin
            if (!cnt[SHW]) begin
                acc <= acc_step;
                cnt <= cnt + {{SHW{1'b0}}, 1'b1};
            end else begin
                f_xo       <= acc[WIDTH-1:0];
                zero_xo    <= (acc[WIDTH-1:0] == '0);
                neg_xo     <= acc[WIDTH-1];
                carry_xo   <= 1'b0;
                ovf_xo     <= |acc[2*WIDTH-1:WIDTH];
                illegal_xo <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_multi_func_alu_seq.sv
// Self-checking bench for multi_func_alu_seq (WIDTH=32): directed corner cases,
// MUL latency, backpressure/streaming, reset mid-MUL and randomized ops vs a reference model.
module tb_multi_func_alu_seq;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    op = '0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  f;
    logic          zero, neg, carry, ovf, illegal;

    int n_checks = 0;
    int n_fail   = 0;
    logic [36:0] exp_q[$];

    multi_func_alu_seq #(.WIDTH(W)) dut (
        .clk_xi(clk), .rst_n_xi(rst_n), .in_valid_xi(in_valid), .in_ready_xo(in_ready),
        .op_xi(op), .a_xi(a), .b_xi(b), .out_valid_xo(out_valid), .out_ready_xi(out_ready),
        .f_xo(f), .zero_xo(zero), .neg_xo(neg), .carry_xo(carry), .ovf_xo(ovf),
        .illegal_xo(illegal)
    );

    always #5 clk = ~clk;

    wire [36:0] got = {illegal, ovf, carry, neg, zero, f};

    // Reference model: {illegal, ovf, carry, neg, zero, f} from plain integer arithmetic.
    function automatic logic [36:0] model(input logic [3:0] m_op, input logic [W-1:0] x,
                                          input logic [W-1:0] y);
        logic [W-1:0] r;
        logic c, v, il;
        longint sx, sy, s;
        logic [63:0] p;
        int amt;
        r = '0; c = 1'b0; v = 1'b0; il = 1'b0;
        sx = $signed(x);
        sy = $signed(y);
        amt = int'(x % 32);
        case (m_op)
            4'd0: r = x & y;
            4'd1: r = x | y;
            4'd2: r = x ^ y;
            4'd3: r = ~(x | y);
            4'd4: begin
                p = 64'(x) + 64'(y);
                r = p[W-1:0];
                c = (p > 64'h0000_0000_FFFF_FFFF);
                s = sx + sy;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd5: begin
                r = x - y;
                c = (x < y);
                s = sx - sy;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd6:  r = (x < y) ? 32'd1 : 32'd0;
            4'd7:  r = y << amt;
            4'd8:  r = y >> amt;
            4'd9:  begin s = sy >>> amt; r = s[W-1:0]; end
            4'd10: r = (sx < sy) ? 32'd1 : 32'd0;
            4'd11: begin
                p = 64'(x) * 64'(y);
                r = p[W-1:0];
                v = (p >= 64'h1_0000_0000);
            end
            default: il = 1'b1;
        endcase
        return {il, v, c, r[W-1], (r == 0) && !il, r};
    endfunction

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Driver: present a request and hold it until the block takes it.
    task automatic issue(input logic [3:0] i_op, input logic [W-1:0] i_a, input logic [W-1:0] i_b);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1; op = i_op; a = i_a; b = i_b;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_checks++; n_fail++;
            $display("FAIL issue_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, n);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = 4'($urandom); a = $urandom; b = $urandom;
    endtask

    // Waits at negedges for out_valid; cyc = clock edges since accept, -1 on timeout.
    task automatic wait_valid(output int cyc, output int ready_while_busy);
        cyc = 0;
        ready_while_busy = 0;
        @(negedge clk);
        while (!out_valid && cyc < 60) begin
            if (in_ready) ready_while_busy++;
            @(negedge clk);
            cyc++;
        end
        if (!out_valid) cyc = -1;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({out_valid, got} !== 38'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid/result=%h required 0", {out_valid, got});
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_ready: in_ready,out_valid=%b required 10", {in_ready, out_valid});
        end
    endtask

    task automatic test_directed();
        logic [3:0]  d_op[12];
        logic [W-1:0] d_a[12];
        logic [W-1:0] d_b[12];
        logic [36:0] d_exp[12];
        int cyc, rdy;
        d_op  = '{4'd4, 4'd5, 4'd5, 4'd9, 4'd8, 4'd10, 4'd6, 4'd13, 4'd3, 4'd7, 4'd0, 4'd4};
        d_a   = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h1, 32'h4, 32'h4, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                  32'h1234_5678, 32'h0, 32'd31, 32'hF0F0_F0F0, 32'h7FFF_FFFF};
        d_b   = '{32'h1, 32'h1, 32'h2, 32'h8000_0000, 32'h8000_0000, 32'h1, 32'h1,
                  32'h9ABC_DEF0, 32'h0, 32'h1, 32'hFF00_FF00, 32'h1};
        d_exp = '{37'h05_0000_0000, 37'h08_7FFF_FFFF, 37'h06_FFFF_FFFF, 37'h02_F800_0000,
                  37'h00_0800_0000, 37'h00_0000_0001, 37'h01_0000_0000, 37'h10_0000_0000,
                  37'h02_FFFF_FFFF, 37'h02_8000_0000, 37'h02_F000_F000, 37'h0A_8000_0000};
        for (int i = 0; i < 12; i++) begin
            issue(d_op[i], d_a[i], d_b[i]);
            wait_valid(cyc, rdy);
            n_checks++;
            if (cyc !== 0 || got !== d_exp[i]) begin
                n_fail++;
                $display("FAIL directed_%0d op=%0d: latency=%0d result=%h required latency=0 result=%h",
                         i, d_op[i], cyc, got, d_exp[i]);
            end
            consume();
        end
    endtask

    task automatic test_mul_latency();
        int cyc, rdy;
        issue(4'd11, 32'h0001_0000, 32'h0001_0000);
        wait_valid(cyc, rdy);
        n_checks++;
        if (cyc !== 33) begin
            n_fail++;
            $display("FAIL mul_latency: %0d cycles, required 33", cyc);
        end
        n_checks++;
        if (rdy !== 0) begin
            n_fail++;
            $display("FAIL mul_busy_ready: in_ready high %0d busy cycles, required 0", rdy);
        end
        n_checks++;
        if (got !== 37'h09_0000_0000) begin
            n_fail++;
            $display("FAIL mul_result: %h required %h", got, 37'h09_0000_0000);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        logic [3:0]  s_op[4];
        logic [W-1:0] s_a[4];
        logic [W-1:0] s_b[4];
        int cyc, rdy;
        out_ready = 1'b0;
        issue(4'd4, 32'd3, 32'd4);
        wait_valid(cyc, rdy);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({out_valid, in_ready, got} !== {2'b10, 37'h00_0000_0007}) begin
                n_fail++;
                $display("FAIL hold_%0d: valid,ready,result=%h required %h", i,
                         {out_valid, in_ready, got}, {2'b10, 37'h00_0000_0007});
            end
            @(negedge clk);
        end
        for (int i = 0; i < 4; i++) begin
            s_op[i] = 4'($urandom_range(0, 10));
            s_a[i]  = pick_operand();
            s_b[i]  = pick_operand();
            exp_q.push_back(model(s_op[i], s_a[i], s_b[i]));
        end
        out_ready = 1'b1;
        in_valid = 1'b1; op = s_op[0]; a = s_a[0]; b = s_b[0];
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || got !== exp_q[0]) begin
                n_fail++;
                $display("FAIL stream_%0d op=%0d: valid=%b result=%h required valid=1 result=%h",
                         i, s_op[i], out_valid, got, exp_q[0]);
            end
            void'(exp_q.pop_front());
            if (i < 3) begin
                op = s_op[i+1]; a = s_a[i+1]; b = s_b[i+1];
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_drain: out_valid=%b required 0", out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_mul();
        int pulses;
        issue(4'd11, 32'hDEAD_BEEF, 32'h1234_5678);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, got} !== 38'h0) begin
            n_fail++;
            $display("FAIL reset_mid_mul: valid/result=%h required 0", {out_valid, got});
        end
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        n_checks++;
        if (pulses !== 0 || in_ready !== 1'b1 || f !== '0) begin
            n_fail++;
            $display("FAIL after_reset_mul: valid pulses=%0d in_ready=%b f=%h required 0,1,0",
                     pulses, in_ready, f);
        end
    endtask

    task automatic test_random();
        logic [3:0]  r_op;
        logic [W-1:0] r_a, r_b;
        int cyc, rdy, hold;
        for (int i = 0; i < 150; i++) begin
            r_op = 4'($urandom_range(0, 15));
            r_a  = pick_operand();
            r_b  = pick_operand();
            exp_q.push_back(model(r_op, r_a, r_b));
            issue(r_op, r_a, r_b);
            wait_valid(cyc, rdy);
            n_checks++;
            if (cyc !== ((r_op == 4'd11) ? 33 : 0) || rdy !== 0) begin
                n_fail++;
                $display("FAIL rand_latency_%0d op=%0d: latency=%0d busy_ready=%0d required %0d,0",
                         i, r_op, cyc, rdy, (r_op == 4'd11) ? 33 : 0);
            end
            hold = $urandom_range(0, 2);
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                n_checks++;
                if ({out_valid, in_ready, got} !== {2'b10, exp_q[0]}) begin
                    n_fail++;
                    $display("FAIL rand_hold_%0d: valid,ready,result=%h required %h", i,
                             {out_valid, in_ready, got}, {2'b10, exp_q[0]});
                end
            end
            n_checks++;
            if (got !== exp_q[0]) begin
                n_fail++;
                $display("FAIL rand_result_%0d op=%0d a=%h b=%h: %h required %h",
                         i, r_op, r_a, r_b, got, exp_q[0]);
            end
            void'(exp_q.pop_front());
            consume();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mul_latency();
        test_back_to_back();
        test_reset_mid_mul();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
